fifo_ram_ctrl: RTL and testbench

- Synchronous FIFO controller that drives an external dual-port RAM.
- Port 0 of the RAM is the write port. Port 1 is the read port, with 1-cycle registered read data.
- Converts a valid/ready write stream into RAM writes.
- Issues RAM reads and re-presents the data as a first-word-fall-through valid/ready read stream through a 3-entry output buffer.
- Sits between producer/consumer logic and the RAM macro; it is the initiator for both RAM ports.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_out_buf.sv | 61 ++++++
 rtl/fifo_ram_ctrl.sv | 141 ++++++++++++++
 tb/tb_fifo_ram_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for RAM-backed FIFO controllers.
package fifo_pkg;

  localparam int unsigned OB_DEPTH   = 3;
  localparam int unsigned RAM_RD_LAT = 1;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned OB_CNT_W = cnt_width(OB_DEPTH);

endpackage

// File: rtl/fifo_out_buf.sv
// Small register FIFO with shift-down storage; entry 0 is always the head.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = OB_DEPTH,
  parameter int unsigned CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      cnt
);

  logic [DATA_WIDTH-1:0] mem_q   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_nxt [DEPTH];
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [CNT_W-1:0]      wpos;
  logic                  do_pop;
  logic                  do_push;

  // Storage update: shift on pop, then drop the new word behind the survivors.
  always_comb begin
    do_pop  = pop & (cnt_q != '0);
    do_push = push & ((cnt_q != CNT_W'(DEPTH)) | do_pop);
    wpos    = cnt_q - CNT_W'(do_pop);
    for (int i = 0; i < int'(DEPTH); i++) mem_nxt[i] = mem_q[i];
    if (do_pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) mem_nxt[i] = mem_q[i+1];
    end
    if (do_push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CNT_W'(i) == wpos) mem_nxt[i] = din;
      end
    end
    if (clr) cnt_nxt = '0;
    else     cnt_nxt = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_nxt[i];
    end
  end

  assign head = mem_q[0];
  assign cnt  = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !do_pop && cnt_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller over an external dual-port RAM with a first-word-fall-through
// read side fed by a small output buffer.
module fifo_ram_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] ram_addr_0,
  output logic                  ram_ce_0,
  output logic                  ram_we_0,
  output logic [DATA_WIDTH-1:0] ram_data_0,
  output logic [ADDR_WIDTH-1:0] ram_addr_1,
  output logic                  ram_ce_1,
  output logic                  ram_we_1,
  input  logic [DATA_WIDTH-1:0] ram_data_1
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned OCC_W     = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W     = ADDR_WIDTH + 2;
  localparam int unsigned PEND_W    = OB_CNT_W + 1;

  logic                  ready_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_nxt;
  logic [OCC_W-1:0]      ram_occ_q, ram_occ_nxt;
  logic [RAM_RD_LAT-1:0] inflight_q, inflight_nxt;
  logic [CNT_W-1:0]      count_q, count_nxt;
  logic                  full_q, full_nxt;
  logic                  empty_q, empty_nxt;

  logic [OB_CNT_W-1:0]   ob_cnt;
  logic [DATA_WIDTH-1:0] ob_head;
  logic [PEND_W-1:0]     pend;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  capture;

  // Handshakes and RAM port drive; full is registered so no write pass-through.
  always_comb begin
    wr_ready = ready_q & ~full_q & ~clr;
    push     = wr_valid & wr_ready;
    rd_valid = (ob_cnt != '0);
    pop      = rd_valid & rd_ready;
    pend     = PEND_W'(ob_cnt) + PEND_W'($countones(inflight_q));
    issue    = (ram_occ_q != '0) & (pend < PEND_W'(OB_DEPTH)) & ~clr;
    capture  = inflight_q[RAM_RD_LAT-1];
  end

  assign ram_ce_0   = push;
  assign ram_we_0   = push;
  assign ram_addr_0 = wr_ptr_q;
  assign ram_data_0 = wr_data;
  assign ram_ce_1   = issue;
  assign ram_we_1   = 1'b0;
  assign ram_addr_1 = rd_ptr_q;

  // Next-state for pointers and occupancy bookkeeping.
  always_comb begin
    wr_ptr_nxt   = wr_ptr_q;
    rd_ptr_nxt   = rd_ptr_q;
    ram_occ_nxt  = ram_occ_q;
    inflight_nxt = inflight_q;
    count_nxt    = count_q;
    if (clr) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      ram_occ_nxt  = '0;
      inflight_nxt = '0;
      count_nxt    = '0;
    end else begin
      if (push)  wr_ptr_nxt = wr_ptr_q + ADDR_WIDTH'(1);
      if (issue) rd_ptr_nxt = rd_ptr_q + ADDR_WIDTH'(1);
      ram_occ_nxt  = ram_occ_q + OCC_W'(push) - OCC_W'(issue);
      inflight_nxt = RAM_RD_LAT'({inflight_q, issue});
      count_nxt    = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    full_nxt  = (ram_occ_nxt == OCC_W'(RAM_DEPTH));
    empty_nxt = (count_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_occ_q  <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      ready_q    <= 1'b1;
      wr_ptr_q   <= wr_ptr_nxt;
      rd_ptr_q   <= rd_ptr_nxt;
      ram_occ_q  <= ram_occ_nxt;
      inflight_q <= inflight_nxt;
      count_q    <= count_nxt;
      full_q     <= full_nxt;
      empty_q    <= empty_nxt;
    end
  end

  fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OB_DEPTH),
    .CNT_W      (OB_CNT_W)
  ) u_out_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (capture),
    .din   (ram_data_1),
    .pop   (pop),
    .head  (ob_head),
    .cnt   (ob_cnt)
  );

  assign rd_data = ob_head;
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

  a_pend_bound: assert property (@(posedge clk) disable iff (!rst_n)
    pend <= PEND_W'(OB_DEPTH));

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Directed bench for fifo_ram_ctrl on a 4-deep RAM model.
module tb_fifo_ram_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW+1:0] count;
  logic          full;
  logic          empty;
  logic [AW-1:0] ram_addr_0;
  logic          ram_ce_0;
  logic          ram_we_0;
  logic [DW-1:0] ram_data_0;
  logic [AW-1:0] ram_addr_1;
  logic          ram_ce_1;
  logic          ram_we_1;
  logic [DW-1:0] ram_data_1;

  logic [DW-1:0] ram [1 << AW];

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          clr;
    logic          wv;
    logic [7:0]    wd;
    logic          rr;
    logic          wrdy;
    logic          ce0;
    logic [1:0]    a0;
    logic          ce1;
    logic [1:0]    a1;
    logic          rv;
    logic [7:0]    rd;
    logic [3:0]    cnt;
    logic          full;
    logic          empty;
  } vec_t;

  vec_t vecs[$];

  fifo_ram_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ram_addr_0 (ram_addr_0),
    .ram_ce_0   (ram_ce_0),
    .ram_we_0   (ram_we_0),
    .ram_data_0 (ram_data_0),
    .ram_addr_1 (ram_addr_1),
    .ram_ce_1   (ram_ce_1),
    .ram_we_1   (ram_we_1),
    .ram_data_1 (ram_data_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port RAM macro: port 0 writes, port 1 reads with one cycle latency.
  always @(posedge clk) begin
    if (ram_ce_0 && ram_we_0) ram[ram_addr_0] <= ram_data_0;
    if (ram_ce_1 && !ram_we_1) ram_data_1 <= ram[ram_addr_1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int c, input int w, input int d, input int r,
                              input int wrdy, input int ce0, input int a0,
                              input int ce1, input int a1, input int rv, input int rd,
                              input int cnt, input int fu, input int em);
    vec_t v;
    v.clr = 1'(c);    v.wv = 1'(w);     v.wd = 8'(d);    v.rr = 1'(r);
    v.wrdy = 1'(wrdy); v.ce0 = 1'(ce0); v.a0 = 2'(a0);   v.ce1 = 1'(ce1);
    v.a1 = 2'(a1);    v.rv = 1'(rv);    v.rd = 8'(rd);   v.cnt = 4'(cnt);
    v.full = 1'(fu);  v.empty = 1'(em);
    return v;
  endfunction

  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    clr = v.clr; wr_valid = v.wv; wr_data = v.wd; rd_ready = v.rr;
    #1;
    chk($sformatf("v%0d.wr_ready", idx), 32'(wr_ready), 32'(v.wrdy));
    chk($sformatf("v%0d.ram_ce_0", idx), 32'(ram_ce_0), 32'(v.ce0));
    chk($sformatf("v%0d.ram_we_0", idx), 32'(ram_we_0), 32'(v.ce0));
    chk($sformatf("v%0d.ram_addr_0", idx), 32'(ram_addr_0), 32'(v.a0));
    chk($sformatf("v%0d.ram_ce_1", idx), 32'(ram_ce_1), 32'(v.ce1));
    chk($sformatf("v%0d.ram_addr_1", idx), 32'(ram_addr_1), 32'(v.a1));
    chk($sformatf("v%0d.rd_valid", idx), 32'(rd_valid), 32'(v.rv));
    if (v.rv) chk($sformatf("v%0d.rd_data", idx), 32'(rd_data), 32'(v.rd));
    chk($sformatf("v%0d.count", idx), 32'(count), 32'(v.cnt));
    chk($sformatf("v%0d.full", idx), 32'(full), 32'(v.full));
    chk($sformatf("v%0d.empty", idx), 32'(empty), 32'(v.empty));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, ".count"},    32'(count),    32'd0);
    chk({tag, ".empty"},    32'(empty),    32'd1);
    chk({tag, ".full"},     32'(full),     32'd0);
    chk({tag, ".wr_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, ".ram_ce_0"}, 32'(ram_ce_0), 32'd0);
    chk({tag, ".ram_ce_1"}, 32'(ram_ce_1), 32'd0);
    chk({tag, ".ram_we_1"}, 32'(ram_we_1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed, popped, first_push, first_pop, last_pop, wait_cyc;
    rst_n = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    //       clr wv wd     rr | wrdy ce0 a0 ce1 a1 rv rd     cnt full empty
    // single push, first-word latency, hold until taken
    vecs.push_back(mk(0, 0, 'h00, 0,  1, 0, 0, 0, 0, 0, 'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 'hA5, 0,  1, 1, 0, 0, 0, 0, 'h00, 0, 0, 1));
    vecs.push_back(mk(0, 0, 'h00, 0,  1, 0, 1, 1, 0, 0, 'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 0,  1, 0, 1, 0, 1, 0, 'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 0,  1, 0, 1, 0, 1, 1, 'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 0,  1, 0, 1, 0, 1, 1, 'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 1,  1, 0, 1, 0, 1, 1, 'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 0,  1, 0, 1, 0, 1, 0, 'h00, 0, 0, 1));
    // fill with consumer stalled: 4 RAM + 3 buffer words, then full
    vecs.push_back(mk(0, 1, 'h00, 0,  1, 1, 1, 0, 1, 0, 'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 'h01, 0,  1, 1, 2, 1, 1, 0, 'h00, 1, 0, 0));
    vecs.push_back(mk(0, 1, 'h02, 0,  1, 1, 3, 1, 2, 0, 'h00, 2, 0, 0));
    vecs.push_back(mk(0, 1, 'h03, 0,  1, 1, 0, 1, 3, 1, 'h00, 3, 0, 0));
    vecs.push_back(mk(0, 1, 'h04, 0,  1, 1, 1, 0, 0, 1, 'h00, 4, 0, 0));
    vecs.push_back(mk(0, 1, 'h05, 0,  1, 1, 2, 0, 0, 1, 'h00, 5, 0, 0));
    vecs.push_back(mk(0, 1, 'h06, 0,  1, 1, 3, 0, 0, 1, 'h00, 6, 0, 0));
    vecs.push_back(mk(0, 1, 'h07, 0,  0, 0, 0, 0, 0, 1, 'h00, 7, 1, 0));
    vecs.push_back(mk(0, 1, 'h07, 0,  0, 0, 0, 0, 0, 1, 'h00, 7, 1, 0));
    // drain in order; full drops after the first issue
    vecs.push_back(mk(0, 0, 'h00, 1,  0, 0, 0, 0, 0, 1, 'h00, 7, 1, 0));
    vecs.push_back(mk(0, 0, 'h00, 1,  0, 0, 0, 1, 0, 1, 'h01, 6, 1, 0));
    vecs.push_back(mk(0, 0, 'h00, 1,  1, 0, 0, 1, 1, 1, 'h02, 5, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 1,  1, 0, 0, 1, 2, 1, 'h03, 4, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 1,  1, 0, 0, 1, 3, 1, 'h04, 3, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 1,  1, 0, 0, 0, 0, 1, 'h05, 2, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 1,  1, 0, 0, 0, 0, 1, 'h06, 1, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 1,  1, 0, 0, 0, 0, 0, 'h00, 0, 0, 1));
    // build count=5 with a read in flight, then clr where an issue would occur
    vecs.push_back(mk(0, 1, 'h50, 0,  1, 1, 0, 0, 0, 0, 'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 'h51, 0,  1, 1, 1, 1, 0, 0, 'h00, 1, 0, 0));
    vecs.push_back(mk(0, 1, 'h52, 0,  1, 1, 2, 1, 1, 0, 'h00, 2, 0, 0));
    vecs.push_back(mk(0, 1, 'h53, 0,  1, 1, 3, 1, 2, 1, 'h50, 3, 0, 0));
    vecs.push_back(mk(0, 1, 'h54, 0,  1, 1, 0, 0, 3, 1, 'h50, 4, 0, 0));
    vecs.push_back(mk(0, 1, 'h55, 1,  1, 1, 1, 0, 3, 1, 'h50, 5, 0, 0));
    vecs.push_back(mk(0, 1, 'h56, 1,  1, 1, 2, 1, 3, 1, 'h51, 5, 0, 0));
    vecs.push_back(mk(1, 1, 'h99, 0,  0, 0, 3, 0, 0, 1, 'h52, 5, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 0,  1, 0, 0, 0, 0, 0, 'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 'h3C, 0,  1, 1, 0, 0, 0, 0, 'h00, 0, 0, 1));
    vecs.push_back(mk(0, 0, 'h00, 0,  1, 0, 1, 1, 0, 0, 'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 0,  1, 0, 1, 0, 1, 0, 'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 1,  1, 0, 1, 0, 1, 1, 'h3C, 1, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 0,  1, 0, 1, 0, 1, 0, 'h00, 0, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // Streaming: 20 words, expect one per cycle after a 3-cycle fill.
    pushed = 0; popped = 0; first_push = -1; first_pop = -1; last_pop = -1;
    for (int cyc = 0; cyc < 80 && popped < 20; cyc++) begin
      @(negedge clk);
      clr = 1'b0; rd_ready = 1'b1;
      wr_valid = (pushed < 20);
      wr_data  = 8'(32'h10 + 32'(pushed));
      #1;
      if (wr_valid && wr_ready) begin
        if (first_push < 0) first_push = cyc;
        pushed++;
      end
      if (rd_valid) begin
        chk($sformatf("stream.data%0d", popped), 32'(rd_data), 32'h10 + 32'(popped));
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        popped++;
      end
    end
    chk("stream.popped", 32'(popped), 32'd20);
    chk("stream.fill_latency", 32'(first_pop - first_push), 32'd3);
    chk("stream.throughput", 32'(last_pop - first_pop), 32'd19);

    // Asynchronous reset mid-stream, between clock edges.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_valid = 1'b1; rd_ready = 1'b0; wr_data = 8'(32'h60 + 32'(i));
    end
    #1;
    chk("midrst.pre_rd_valid", 32'(rd_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 8'h77;
    #1;
    chk("post.ram_ce_0", 32'(ram_ce_0), 32'd1);
    chk("post.ram_addr_0", 32'(ram_addr_0), 32'd0);
    wait_cyc = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      if (rd_valid) begin
        wait_cyc = k;
        break;
      end
    end
    chk("post.latency", 32'(wait_cyc), 32'd3);
    chk("post.rd_data", 32'(rd_data), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
